// File: rtl/i_instr_decoder_if.sv
// i_instr_decoder_if: decode request/response bundle; imm_sext exists only when I_INSTR_DECODER_IMM64_EN is defined
interface i_instr_decoder_if;
    logic        valid;
    logic [31:0] instr;
    logic        out_valid;
    logic [1:0]  fmt;
    logic        out_illegal;
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [4:0]  rd;
    logic [11:0] imm_val;
`ifdef I_INSTR_DECODER_IMM64_EN
    logic [63:0] imm_sext;
    modport master (output valid, instr,
                    input out_valid, fmt, out_illegal, opcode, funct3, funct7, rs1, rs2, rd, imm_val, imm_sext);
    modport slave (input valid, instr,
                   output out_valid, fmt, out_illegal, opcode, funct3, funct7, rs1, rs2, rd, imm_val, imm_sext);
`else
    modport master (output valid, instr,
                    input out_valid, fmt, out_illegal, opcode, funct3, funct7, rs1, rs2, rd, imm_val);
    modport slave (input valid, instr,
                   output out_valid, fmt, out_illegal, opcode, funct3, funct7, rs1, rs2, rd, imm_val);
`endif
endinterface

// File: rtl/i_instr_decoder.sv
// i_instr_decoder: registered RV64 I/R/S field decoder; I_INSTR_DECODER_IMM64_EN adds a sign-extended imm_sext output
module i_instr_decoder (
    input logic           clk,
    input logic           reset,
    i_instr_decoder_if.slave dec
);
    logic [6:0]  op;
    logic        is_i, is_r, is_s, legal;
    logic        out_valid_d, out_valid_q;
    logic [1:0]  fmt_d, fmt_q;
    logic        illegal_d, illegal_q;
    logic [6:0]  opcode_d, opcode_q;
    logic [2:0]  funct3_d, funct3_q;
    logic [6:0]  funct7_d, funct7_q;
    logic [4:0]  rs1_d, rs1_q, rs2_d, rs2_q, rd_d, rd_q;
    logic [11:0] imm_val_d, imm_val_q;
`ifdef I_INSTR_DECODER_IMM64_EN
    logic [63:0] imm_sext_d, imm_sext_q;
`endif

    // classify the opcode and pick the next field values; fields hold when no instr is presented
    always_comb begin
        op          = dec.instr[6:0];
        is_i        = op inside {7'b0000011, 7'b0010011, 7'b0011011, 7'b1100111, 7'b1110011};
        is_r        = op inside {7'b0110011, 7'b0111011};
        is_s        = op == 7'b0100011;
        legal       = is_i | is_r | is_s;
        out_valid_d = dec.valid;
        fmt_d       = !dec.valid ? fmt_q : is_i ? 2'b01 : is_r ? 2'b10 : is_s ? 2'b11 : 2'b00;
        illegal_d   = dec.valid ? !legal : illegal_q;
        opcode_d    = dec.valid ? op : opcode_q;
        funct3_d    = dec.valid ? (legal ? dec.instr[14:12] : 3'd0) : funct3_q;
        funct7_d    = dec.valid ? (is_r ? dec.instr[31:25] : 7'd0) : funct7_q;
        rs1_d       = dec.valid ? (legal ? dec.instr[19:15] : 5'd0) : rs1_q;
        rs2_d       = dec.valid ? (is_r | is_s ? dec.instr[24:20] : 5'd0) : rs2_q;
        rd_d        = dec.valid ? (is_i | is_r ? dec.instr[11:7] : 5'd0) : rd_q;
        imm_val_d   = !dec.valid ? imm_val_q : is_i ? dec.instr[31:20] :
                      is_s ? {dec.instr[31:25], dec.instr[11:7]} : 12'd0;
`ifdef I_INSTR_DECODER_IMM64_EN
        imm_sext_d  = {{52{imm_val_d[11]}}, imm_val_d};
`endif
    end

    // output registers; reset clears everything immediately, discarding any in-flight instr
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            out_valid_q <= 1'b0;
            fmt_q       <= 2'b00;
            illegal_q   <= 1'b0;
            opcode_q    <= '0;
            funct3_q    <= '0;
            funct7_q    <= '0;
            rs1_q       <= '0;
            rs2_q       <= '0;
            rd_q        <= '0;
            imm_val_q   <= '0;
`ifdef I_INSTR_DECODER_IMM64_EN
            imm_sext_q  <= '0;
`endif
        end else begin
            out_valid_q <= out_valid_d;
            fmt_q       <= fmt_d;
            illegal_q   <= illegal_d;
            opcode_q    <= opcode_d;
            funct3_q    <= funct3_d;
            funct7_q    <= funct7_d;
            rs1_q       <= rs1_d;
            rs2_q       <= rs2_d;
            rd_q        <= rd_d;
            imm_val_q   <= imm_val_d;
`ifdef I_INSTR_DECODER_IMM64_EN
            imm_sext_q  <= imm_sext_d;
`endif
        end
    end

    assign dec.out_valid   = out_valid_q;
    assign dec.fmt         = fmt_q;
    assign dec.out_illegal = illegal_q;
    assign dec.opcode      = opcode_q;
    assign dec.funct3      = funct3_q;
    assign dec.funct7      = funct7_q;
    assign dec.rs1         = rs1_q;
    assign dec.rs2         = rs2_q;
    assign dec.rd          = rd_q;
    assign dec.imm_val     = imm_val_q;
`ifdef I_INSTR_DECODER_IMM64_EN
    assign dec.imm_sext    = imm_sext_q;
`endif
endmodule

// File: tb/tb_i_instr_decoder.sv
// tb_i_instr_decoder: directed-vector bench for i_instr_decoder (imm_sext checks when I_INSTR_DECODER_IMM64_EN is defined)
module tb_i_instr_decoder;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int total = 0;
    int passed = 0;

    i_instr_decoder_if dif();
    i_instr_decoder dut (.clk(clk), .reset(reset), .dec(dif));

    always #5 clk = ~clk;

    // expected-vector layout: {out_valid, fmt, illegal, opcode, funct3, funct7, rs1, rs2, rd, imm_val}
    function automatic logic [47:0] pack(input logic v, input logic [1:0] f, input logic ill,
                                         input logic [6:0] op, input logic [2:0] f3, input logic [6:0] f7,
                                         input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                                         input logic [11:0] imm);
        return {v, f, ill, op, f3, f7, s1, s2, d, imm};
    endfunction

    function automatic logic [47:0] obs();
        return {dif.out_valid, dif.fmt, dif.out_illegal, dif.opcode, dif.funct3, dif.funct7,
                dif.rs1, dif.rs2, dif.rd, dif.imm_val};
    endfunction

    task automatic issue(input logic v, input logic [31:0] w);
        @(negedge clk);
        dif.valid = v;
        dif.instr = w;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        logic [47:0] e;
        dif.valid = 1'b1;
        dif.instr = 32'h00500093;
        repeat (2) @(posedge clk);
        #1;
        e = '0;
        total++;
        if (obs() !== e) $display("FAIL reset_hold: got %h expected %h", obs(), e); else passed++;
`ifdef I_INSTR_DECODER_IMM64_EN
        total++;
        if (dif.imm_sext !== 64'd0) $display("FAIL reset_sext: got %h expected 0", dif.imm_sext); else passed++;
`endif
        @(negedge clk);
        dif.valid = 1'b0;
        reset = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (obs() !== e) $display("FAIL reset_idle: got %h expected %h", obs(), e); else passed++;
    endtask

    task automatic test_i_format();
        logic [47:0] e;
        issue(1'b1, 32'h00500093);
        e = pack(1, 2'b01, 0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'h005);
        total++;
        if (obs() !== e) $display("FAIL addi: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'hFFF00093);
        e = pack(1, 2'b01, 0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'hFFF);
        total++;
        if (obs() !== e) $display("FAIL addi_neg: got %h expected %h", obs(), e); else passed++;
`ifdef I_INSTR_DECODER_IMM64_EN
        total++;
        if (dif.imm_sext !== 64'hFFFF_FFFF_FFFF_FFFF)
            $display("FAIL sext_neg: got %h expected ffffffffffffffff", dif.imm_sext); else passed++;
`endif
        issue(1'b1, 32'h03F11093);
        e = pack(1, 2'b01, 0, 7'h13, 3'd1, 7'd0, 5'd2, 5'd0, 5'd1, 12'h03F);
        total++;
        if (obs() !== e) $display("FAIL slli: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h40335293);
        e = pack(1, 2'b01, 0, 7'h13, 3'd5, 7'd0, 5'd6, 5'd0, 5'd5, 12'h403);
        total++;
        if (obs() !== e) $display("FAIL srai: got %h expected %h", obs(), e); else passed++;
`ifdef I_INSTR_DECODER_IMM64_EN
        total++;
        if (dif.imm_sext !== 64'h403) $display("FAIL sext_pos: got %h expected 403", dif.imm_sext); else passed++;
`endif
        issue(1'b1, 32'hFF813383);
        e = pack(1, 2'b01, 0, 7'h03, 3'd3, 7'd0, 5'd2, 5'd0, 5'd7, 12'hFF8);
        total++;
        if (obs() !== e) $display("FAIL ld: got %h expected %h", obs(), e); else passed++;
    endtask

    task automatic test_r_format();
        logic [47:0] e;
        issue(1'b1, 32'h002081B3);
        e = pack(1, 2'b10, 0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL add: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h402081B3);
        e = pack(1, 2'b10, 0, 7'h33, 3'd0, 7'h20, 5'd1, 5'd2, 5'd3, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL sub: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h0062823B);
        e = pack(1, 2'b10, 0, 7'h3B, 3'd0, 7'h00, 5'd5, 5'd6, 5'd4, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL addw: got %h expected %h", obs(), e); else passed++;
    endtask

    task automatic test_s_format();
        logic [47:0] e;
        issue(1'b1, 32'h0020B423);
        e = pack(1, 2'b11, 0, 7'h23, 3'd3, 7'd0, 5'd1, 5'd2, 5'd0, 12'h008);
        total++;
        if (obs() !== e) $display("FAIL sd: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'hFEA5AE23);
        e = pack(1, 2'b11, 0, 7'h23, 3'd2, 7'd0, 5'd11, 5'd10, 5'd0, 12'hFFC);
        total++;
        if (obs() !== e) $display("FAIL sw_neg: got %h expected %h", obs(), e); else passed++;
`ifdef I_INSTR_DECODER_IMM64_EN
        total++;
        if (dif.imm_sext !== 64'hFFFF_FFFF_FFFF_FFFC)
            $display("FAIL sext_sw: got %h expected fffffffffffffffc", dif.imm_sext); else passed++;
`endif
    endtask

    task automatic test_illegal();
        logic [47:0] e;
        issue(1'b1, 32'h000000B7);
        e = pack(1, 2'b00, 1, 7'h37, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL lui: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h00000000);
        e = pack(1, 2'b00, 1, 7'h00, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL zero: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h00500091);
        e = pack(1, 2'b00, 1, 7'h11, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL compressed: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'hFFFFFFFF);
        e = pack(1, 2'b00, 1, 7'h7F, 3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL all_ones: got %h expected %h", obs(), e); else passed++;
    endtask

    task automatic test_hold();
        logic [47:0] e;
        issue(1'b1, 32'h002081B3);
        issue(1'b0, 32'hFFF00093);
        e = pack(0, 2'b10, 0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL hold1: got %h expected %h", obs(), e); else passed++;
        issue(1'b0, 32'h00000000);
        total++;
        if (obs() !== e) $display("FAIL hold2: got %h expected %h", obs(), e); else passed++;
    endtask

    task automatic test_back_to_back();
        logic [47:0] e;
        issue(1'b1, 32'h00500093);
        e = pack(1, 2'b01, 0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'h005);
        total++;
        if (obs() !== e) $display("FAIL b2b_0: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h002081B3);
        e = pack(1, 2'b10, 0, 7'h33, 3'd0, 7'h00, 5'd1, 5'd2, 5'd3, 12'h000);
        total++;
        if (obs() !== e) $display("FAIL b2b_1: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h0020B423);
        e = pack(1, 2'b11, 0, 7'h23, 3'd3, 7'd0, 5'd1, 5'd2, 5'd0, 12'h008);
        total++;
        if (obs() !== e) $display("FAIL b2b_2: got %h expected %h", obs(), e); else passed++;
        #2 reset = 1'b1;
        #1;
        e = '0;
        total++;
        if (obs() !== e) $display("FAIL async_reset: got %h expected %h", obs(), e); else passed++;
        @(posedge clk);
        #1;
        total++;
        if (obs() !== e) $display("FAIL reset_discard: got %h expected %h", obs(), e); else passed++;
        @(negedge clk);
        reset = 1'b0;
        dif.valid = 1'b0;
        @(posedge clk);
        #1;
        total++;
        if (obs() !== e) $display("FAIL post_reset_idle: got %h expected %h", obs(), e); else passed++;
        issue(1'b1, 32'h00500093);
        e = pack(1, 2'b01, 0, 7'h13, 3'd0, 7'd0, 5'd0, 5'd0, 5'd1, 12'h005);
        total++;
        if (obs() !== e) $display("FAIL first_accept: got %h expected %h", obs(), e); else passed++;
    endtask

    initial begin
        dif.valid = 1'b0;
        dif.instr = '0;
        test_reset();
        test_i_format();
        test_r_format();
        test_s_format();
        test_illegal();
        test_hold();
        test_back_to_back();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
